// File: rtl/tw_rom_seq_pkg.sv
// Shared encodings for the twiddle ROM sequencer: FSM states and ROM write-half codes.
package tw_rom_seq_pkg;

  // The ROM decodes this value of `state` as "reading twiddles for the current stage".
  localparam logic [3:0] RUN_STATE = 4'd4;

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StCollect = 4'd1,
    StBurstHi = 4'd2,
    StBurstLo = 4'd3,
    StRun     = RUN_STATE,
    StFlush   = 4'd5,
    StArm     = 4'd6,
    StDone    = 4'd7
  } state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_HI   = 2'd1,
    W_LO   = 2'd2
  } rom_w_e;

endpackage

// File: rtl/tw_load_buf.sv
// Collect buffer: stores load words in bus order, replays all high halves then all low halves.
module tw_load_buf #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 64
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [Width-1:0] wr_data,
  input  logic             rd_adv,
  output logic             wr_last,
  output logic [Width-1:0] rd_data
);

  localparam int unsigned IdxW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [IdxW-1:0]  wr_idx_q;
  logic [IdxW-1:0]  rd_idx_q;
  logic [IdxW-1:0]  wr_slot;

  // Load index bit 0 selects the half, so halves land in separate banks for linear readout.
  assign wr_slot = {wr_idx_q[0], wr_idx_q[IdxW-1:1]};
  assign wr_last = wr_en && (wr_idx_q == IdxW'(Depth - 1));
  assign rd_data = mem_q[rd_idx_q];

  always_ff @(posedge CLK) begin
    if (rst || clr) begin
      wr_idx_q <= '0;
      rd_idx_q <= '0;
    end else begin
      if (wr_en) wr_idx_q <= wr_idx_q + 1'b1;
      if (rd_adv) rd_idx_q <= rd_idx_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_slot] <= wr_data;
  end

endmodule

// File: rtl/tw_rom_seq_ctrl.sv
// Twiddle ROM sequencer: reloads stage-0 twiddles as one 8-cycle burst and steps the NTT stages.
module tw_rom_seq_ctrl
  import tw_rom_seq_pkg::*;
#(
  parameter int unsigned SC_WIDTH   = 3,
  parameter int unsigned S_WIDTH    = 4,
  parameter int unsigned HDW        = 64,
  parameter int unsigned NUM_STAGE  = 3,
  parameter int unsigned LOAD_WORDS = 4,
  parameter int unsigned STAGE_LEN  = 256,
  parameter int unsigned CNT_W      = 10
) (
  input  logic                CLK,
  input  logic                rst,
  input  logic                load_start,
  input  logic                run_start,
  input  logic                ld_valid,
  input  logic [HDW-1:0]      ld_data,
  output logic                ld_ready,
  output logic [SC_WIDTH-1:0] stage_counter,
  output logic                CEN,
  output logic [S_WIDTH-1:0]  state,
  output logic [1:0]          ROM5_w,
  output logic [HDW-1:0]      horizontal_data_in,
  output logic                busy,
  output logic                done
);

  localparam logic [CNT_W-1:0]    CycLast   = CNT_W'(STAGE_LEN - 1);
  localparam logic [SC_WIDTH-1:0] LastStage = SC_WIDTH'(NUM_STAGE - 1);

  state_e           st_q;
  logic [CNT_W-1:0] cyc_q;
  logic [1:0]       burst_q;
  logic             beat;
  logic             beat_last;
  logic             buf_clr;
  logic             rd_adv;
  logic [HDW-1:0]   rd_data;

  assign state   = S_WIDTH'(st_q);
  assign beat    = ld_valid && ld_ready;
  assign buf_clr = (st_q == StIdle) && load_start;
  // Advance the read pointer whenever the next burst word is latched onto the ROM bus.
  assign rd_adv  = (st_q == StCollect && beat_last) || (st_q == StBurstHi) ||
                   (st_q == StBurstLo && burst_q != 2'd3);

  tw_load_buf #(
    .Depth (2 * LOAD_WORDS),
    .Width (HDW)
  ) u_load_buf (
    .CLK     (CLK),
    .rst     (rst),
    .clr     (buf_clr),
    .wr_en   (beat),
    .wr_data (ld_data),
    .rd_adv  (rd_adv),
    .wr_last (beat_last),
    .rd_data (rd_data)
  );

  always_ff @(posedge CLK) begin
    if (rst) begin
      st_q               <= StIdle;
      CEN                <= 1'b1;
      ROM5_w             <= W_IDLE;
      horizontal_data_in <= '0;
      stage_counter      <= '0;
      ld_ready           <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      cyc_q              <= '0;
      burst_q            <= '0;
    end else begin
      done <= 1'b0;
      case (st_q)
        StIdle: begin
          if (load_start) begin
            st_q     <= StCollect;
            busy     <= 1'b1;
            ld_ready <= 1'b1;
          end else if (run_start) begin
            st_q          <= StArm;
            busy          <= 1'b1;
            stage_counter <= '0;
          end
        end
        StCollect: begin
          if (beat_last) begin
            st_q               <= StBurstHi;
            ld_ready           <= 1'b0;
            ROM5_w             <= W_HI;
            horizontal_data_in <= rd_data;
            burst_q            <= '0;
          end
        end
        StBurstHi: begin
          horizontal_data_in <= rd_data;
          burst_q            <= burst_q + 2'd1;
          if (burst_q == 2'd3) begin
            st_q   <= StBurstLo;
            ROM5_w <= W_LO;
          end
        end
        StBurstLo: begin
          if (burst_q == 2'd3) begin
            st_q               <= StDone;
            ROM5_w             <= W_IDLE;
            horizontal_data_in <= '0;
            done               <= 1'b1;
          end else begin
            horizontal_data_in <= rd_data;
            burst_q            <= burst_q + 2'd1;
          end
        end
        StArm: begin
          st_q  <= StRun;
          CEN   <= 1'b0;
          cyc_q <= '0;
        end
        StRun: begin
          if (cyc_q == CycLast) begin
            CEN <= 1'b1;
            if (stage_counter < LastStage) begin
              st_q          <= StFlush;
              stage_counter <= stage_counter + 1'b1;
            end else begin
              st_q <= StDone;
              done <= 1'b1;
            end
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        StFlush: begin
          st_q  <= StRun;
          CEN   <= 1'b0;
          cyc_q <= '0;
        end
        StDone: begin
          st_q <= StIdle;
          busy <= 1'b0;
        end
        default: begin
          st_q     <= StIdle;
          CEN      <= 1'b1;
          ROM5_w   <= W_IDLE;
          ld_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tw_rom_seq_ctrl.sv
// Randomised and directed bench for tw_rom_seq_ctrl against a timeline-based behavioural model.
module tb_tw_rom_seq_ctrl;

  localparam int unsigned NS  = 3;
  localparam int unsigned SL  = 4;
  localparam int unsigned HDW = 64;
  localparam int unsigned L   = NS * SL + NS - 1;

  logic           CLK = 1'b0;
  logic           rst, load_start, run_start, ld_valid;
  logic [HDW-1:0] ld_data;
  logic           ld_ready, CEN, busy, done;
  logic [2:0]     stage_counter;
  logic [3:0]     state;
  logic [1:0]     ROM5_w;
  logic [HDW-1:0] horizontal_data_in;

  always #5 CLK = ~CLK;

  tw_rom_seq_ctrl #(
    .SC_WIDTH   (3),
    .S_WIDTH    (4),
    .HDW        (HDW),
    .NUM_STAGE  (NS),
    .LOAD_WORDS (4),
    .STAGE_LEN  (SL),
    .CNT_W      (10)
  ) dut (
    .CLK                (CLK),
    .rst                (rst),
    .load_start         (load_start),
    .run_start          (run_start),
    .ld_valid           (ld_valid),
    .ld_data            (ld_data),
    .ld_ready           (ld_ready),
    .stage_counter      (stage_counter),
    .CEN                (CEN),
    .state              (state),
    .ROM5_w             (ROM5_w),
    .horizontal_data_in (horizontal_data_in),
    .busy               (busy),
    .done               (done)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 collect, 2 burst, 3 run (k=0 is ARM), 4 done; k counts cycles in mode.
  int          m_mode  = 0;
  int          m_k     = 0;
  int          m_beats = 0;
  int          m_sc    = 0;
  logic [63:0] m_words [8];

  always @(posedge CLK) begin
    if (rst) begin
      m_mode = 0; m_k = 0; m_beats = 0; m_sc = 0;
    end else begin
      case (m_mode)
        0: if (load_start) begin
             m_mode = 1; m_beats = 0;
           end else if (run_start) begin
             m_mode = 3; m_k = 0; m_sc = 0;
           end
        1: if (ld_valid) begin
             m_words[m_beats] = ld_data;
             m_beats++;
             if (m_beats == 8) begin m_mode = 2; m_k = 0; end
           end
        2: begin m_k++; if (m_k == 8) m_mode = 4; end
        3: begin m_k++; if (m_k > L) begin m_mode = 4; m_sc = NS - 1; end end
        default: m_mode = 0;
      endcase
    end
  end

  always @(negedge CLK) begin
    int e_state, e_cen, e_w, e_ready, e_busy, e_done, e_sc, j;
    logic [63:0] e_data;
    if (chk_en) begin
      e_state = 0; e_cen = 1; e_w = 0; e_ready = 0; e_done = 0;
      e_busy = (m_mode != 0) ? 1 : 0; e_sc = m_sc; e_data = '0;
      case (m_mode)
        1: begin e_state = 1; e_ready = 1; end
        2: begin
             e_w = (m_k < 4) ? 1 : 2;
             e_state = (m_k < 4) ? 2 : 3;
             e_data = m_words[(m_k % 4) * 2 + m_k / 4];
           end
        3: if (m_k == 0) begin
             e_state = 6; e_sc = 0;
           end else begin
             j = m_k - 1;
             if (j % (SL + 1) == SL) begin
               e_state = 5; e_sc = j / (SL + 1) + 1;
             end else begin
               e_state = 4; e_cen = 0; e_sc = j / (SL + 1);
             end
           end
        4: begin e_state = 7; e_done = 1; end
        default: ;
      endcase
      check("state", 64'(state), 64'(e_state));
      check("CEN", 64'(CEN), 64'(e_cen));
      check("ROM5_w", 64'(ROM5_w), 64'(e_w));
      check("ld_ready", 64'(ld_ready), 64'(e_ready));
      check("busy", 64'(busy), 64'(e_busy));
      check("done", 64'(done), 64'(e_done));
      check("stage_counter", 64'(stage_counter), 64'(e_sc));
      if (e_w != 0) check("horizontal_data_in", horizontal_data_in, e_data);
    end
  end

  logic [63:0] stim_w [8];

  task automatic reload(input bit gapped);
    @(negedge CLK); load_start = 1'b1;
    @(negedge CLK); load_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (gapped) begin ld_valid = 1'b0; @(negedge CLK); end
      ld_valid = 1'b1; ld_data = stim_w[i];
      @(negedge CLK);
    end
    ld_valid = 1'b0;
  endtask

  task automatic pulse_run();
    @(negedge CLK); run_start = 1'b1;
    @(negedge CLK); run_start = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int c = 0;
    while (state != 4'd0 && c < lim) begin @(negedge CLK); c++; end
    check("wait_idle_bounded", 64'(state), 64'd0);
  endtask

  initial begin
    logic [63:0] lit [8];
    int cen0 [3];
    int flushes, done_at, first_cen0, c;
    bit saw_done;

    rst = 1'b1; load_start = 1'b0; run_start = 1'b0; ld_valid = 1'b0; ld_data = '0;
    repeat (2) @(negedge CLK);
    rst = 1'b0; chk_en = 1'b1;

    // Idle after reset.
    repeat (5) begin
      @(negedge CLK);
      check("idle_state", 64'(state), 64'd0);
      check("idle_cen", 64'(CEN), 64'd1);
      check("idle_rom5_w", 64'(ROM5_w), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
    end

    // Gapped reload of 0x11..0x18; burst order hi halves then lo halves.
    for (int i = 0; i < 8; i++) stim_w[i] = 64'h11 + 64'(i);
    lit = '{64'h11, 64'h13, 64'h15, 64'h17, 64'h12, 64'h14, 64'h16, 64'h18};
    reload(1'b1);
    for (int i = 0; i < 8; i++) begin
      check("burst_w_lit", 64'(ROM5_w), (i < 4) ? 64'd1 : 64'd2);
      check("burst_data_lit", horizontal_data_in, lit[i]);
      @(negedge CLK);
    end
    check("reload_done_lit", 64'(done), 64'd1);
    @(negedge CLK);
    check("reload_done_once", 64'(done), 64'd0);
    check("reload_back_idle", 64'(state), 64'd0);

    // Stage run: 4 CEN-low cycles per stage, 2 flushes, 16 cycles ARM..DONE.
    pulse_run();
    cen0 = '{0, 0, 0}; flushes = 0; done_at = -1; first_cen0 = -1; saw_done = 1'b0;
    for (int k = 0; k < 50 && !saw_done; k++) begin
      if (CEN == 1'b0) begin
        if (first_cen0 < 0) first_cen0 = k;
        if (stage_counter < 3) cen0[stage_counter]++;
      end
      if (state == 4'd5) flushes++;
      if (done) begin saw_done = 1'b1; done_at = k; end
      @(negedge CLK);
    end
    check("run_saw_done", 64'(saw_done), 64'd1);
    check("run_len_lit", 64'(done_at + 1), 64'd16);
    check("run_first_cen0", 64'(first_cen0), 64'd1);
    for (int s = 0; s < 3; s++) check("run_cen0_per_stage", 64'(cen0[s]), 64'd4);
    check("run_flushes", 64'(flushes), 64'd2);

    // load_start beats run_start; run_start during COLLECT is ignored.
    @(negedge CLK); load_start = 1'b1; run_start = 1'b1;
    @(negedge CLK); load_start = 1'b0; run_start = 1'b0;
    check("priority_collect", 64'(state), 64'd1);
    run_start = 1'b1;
    @(negedge CLK); run_start = 1'b0;
    check("collect_ignores_run", 64'(state), 64'd1);
    for (int i = 0; i < 8; i++) begin
      ld_valid = 1'b1; ld_data = {$urandom, $urandom};
      @(negedge CLK);
    end
    ld_valid = 1'b0;
    repeat (9) @(negedge CLK);
    check("after_reload_idle", 64'(state), 64'd0);
    check("sc_holds_last", 64'(stage_counter), 64'd2);

    // Reset in the 3rd RUN cycle of stage 1.
    pulse_run();
    c = 0;
    while (!(state == 4'd4 && stage_counter == 3'd1) && c < 40) begin @(negedge CLK); c++; end
    check("reach_stage1", 64'(stage_counter), 64'd1);
    repeat (2) @(negedge CLK);
    rst = 1'b1;
    @(negedge CLK); rst = 1'b0;
    check("rst_run_state", 64'(state), 64'd0);
    check("rst_run_cen", 64'(CEN), 64'd1);
    check("rst_run_sc", 64'(stage_counter), 64'd0);
    check("rst_run_busy", 64'(busy), 64'd0);
    pulse_run();
    check("rerun_arm", 64'(state), 64'd6);
    @(negedge CLK);
    check("rerun_sc0", 64'(stage_counter), 64'd0);
    check("rerun_cen0", 64'(CEN), 64'd0);
    wait_idle(40);

    // Reset during BURST_LO, then a clean reload.
    for (int i = 0; i < 8; i++) stim_w[i] = {$urandom, $urandom};
    reload(1'b0);
    repeat (5) @(negedge CLK);
    check("in_burst_lo", 64'(ROM5_w), 64'd2);
    rst = 1'b1;
    @(negedge CLK); rst = 1'b0;
    check("rst_burst_w", 64'(ROM5_w), 64'd0);
    for (int i = 0; i < 8; i++) stim_w[i] = {$urandom, $urandom};
    reload(1'b1);
    wait_idle(20);

    // Random traffic; the model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      rst        = ($urandom_range(0, 299) == 0);
      load_start = ($urandom_range(0, 29) == 0);
      run_start  = ($urandom_range(0, 29) == 0);
      ld_valid   = $urandom_range(0, 1) == 1;
      ld_data    = {$urandom, $urandom};
    end
    @(negedge CLK);
    rst = 1'b0; load_start = 1'b0; run_start = 1'b0; ld_valid = 1'b0;
    // A load left in COLLECT needs beats to finish; reset clears it instead.
    if (state == 4'd1) begin
      rst = 1'b1;
      @(negedge CLK); rst = 1'b0;
    end
    wait_idle(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
